// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw bouncing push-button input and accepts
// a level change only after DEBOUNCE_CYCLES consecutive stable cycles.
//
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to add auto-repeat, which
// re-pulses btn_rise every REPEAT_CYCLES cycles while the button stays HIGH.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_a_n    in   asynchronous active-low reset
//   btn_raw    in   raw asynchronous button level, active-high
//   btn_level  out  debounced level (registered)
//   btn_rise   out  one-cycle pulse on accepted press / auto-repeat (registered)
//   btn_fall   out  one-cycle pulse on accepted release (registered)
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 25,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic rst_a_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values the counters cannot represent.
  if ((DEBOUNCE_CYCLES < 1) || ((DEBOUNCE_CYCLES >> CNT_W) != 0) ||
      (REPEAT_CYCLES < 1) || ((REPEAT_CYCLES >> CNT_W) != 0)) begin : g_bad_cfg
    $error("button_debouncer: cycle parameters out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  logic             sync1_q;
  logic             sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_q, rpt_d;
`endif

  // Two-flop synchronizer; only sync_q is used downstream.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync_q  <= sync1_q;
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      ST_LOW: begin
        if (sync_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync_q) begin
          state_d = ST_LOW;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!sync_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (sync_q) begin
          state_d = ST_HIGH;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Repeat count restarts on every entry to HIGH and only runs while HIGH
    // is held; it cannot coincide with a fall pulse.
    rpt_d = '0;
    if ((state_q == ST_HIGH) && (state_d == ST_HIGH)) begin
      if (rpt_q == RPT_LAST) begin
        rise_d = 1'b1;
      end else begin
        rpt_d = rpt_q + CNT_W'(1);
      end
    end
`endif

    level_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
module tb_button_debouncer;

  localparam int unsigned DEB = 4;
  localparam int unsigned RPT = 10;
  localparam int unsigned W   = 8;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a_n;
  logic btn_raw;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic raw;
    logic lvl;
    logic rise;
    logic fall;
  } vec_t;

  vec_t vecs[$];

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(W),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk),
    .rst_a_n(rst_a_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  task automatic check_outs(input string tag, input logic lvl, input logic rise,
                            input logic fall);
    check({tag, ".level"}, btn_level, lvl);
    check({tag, ".rise"},  btn_rise,  rise);
    check({tag, ".fall"},  btn_fall,  fall);
  endtask

  // Drive btn_raw, advance one edge, sample 1 time unit later.
  task automatic step(input logic raw, input logic lvl, input logic rise,
                      input logic fall, input string tag);
    btn_raw = raw;
    @(posedge clk);
    #1;
    check_outs(tag, lvl, rise, fall);
  endtask

  initial begin
    logic bounce [10];
    vec_t v;
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Clean release, clean press, clean release; edge k counts from the
    // first edge that samples the new btn_raw value.
    for (int k = 1; k <= 9; k++) begin
      v = '{raw: 1'b0, lvl: (k < 7), rise: 1'b0, fall: (k == 7)};
      vecs.push_back(v);
    end
    for (int k = 1; k <= 9; k++) begin
      v = '{raw: 1'b1, lvl: (k >= 7), rise: (k == 7), fall: 1'b0};
      vecs.push_back(v);
    end
    for (int k = 1; k <= 9; k++) begin
      v = '{raw: 1'b0, lvl: (k < 7), rise: 1'b0, fall: (k == 7)};
      vecs.push_back(v);
    end

    // Held in reset with the button pressed: everything stays low.
    rst_a_n = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outs("in_reset", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step((i % 2) == 1, 1'b0, 1'b0, 1'b0, "in_reset_toggle");

    // Release reset while held: full debounce then a rise on edge 7.
    rst_a_n = 1'b1;
    for (int k = 1; k <= 8; k++) step(1'b1, (k >= 7), (k == 7), 1'b0, $sformatf("held_at_reset_e%0d", k));

    // Table-driven clean release / press / release.
    foreach (vecs[i]) step(vecs[i].raw, vecs[i].lvl, vecs[i].rise, vecs[i].fall, $sformatf("vec%0d", i));

    // Bounce of 1-3 cycle pulses, then settle high.
    for (int i = 0; i < 10; i++) step(bounce[i], 1'b0, 1'b0, 1'b0, $sformatf("bounce%0d", i));
    for (int k = 1; k <= 9; k++) step(1'b1, (k >= 7), (k == 7), 1'b0, $sformatf("settle_e%0d", k));

    // Three-cycle low glitch while high: no fall, level stays up.
    for (int g = 1; g <= 12; g++) step((g > 3), 1'b1, 1'b0, 1'b0, $sformatf("glitch%0d", g));

    // Release back to LOW.
    for (int k = 1; k <= 9; k++) step(1'b0, (k < 7), 1'b0, (k == 7), $sformatf("release_e%0d", k));

    // Long press: repeat pulses at +10/+20/+30 only with auto-repeat.
    for (int k = 1; k <= 7; k++) step(1'b1, (k >= 7), (k == 7), 1'b0, $sformatf("long_press_e%0d", k));
    for (int k = 1; k <= 35; k++) step(1'b1, 1'b1, AR && ((k % 10) == 0), 1'b0, $sformatf("repeat_p%0d", k));

    // Asynchronous reset mid-press: outputs clear at once, no fall later.
    rst_a_n = 1'b0;
    #1;
    check_outs("press_reset_async", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "press_reset_hold");
    rst_a_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("after_press_reset%0d", i));

    // Reset two cycles into WAIT_HIGH: press aborted with no rise.
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("pre_abort_e%0d", k));
    rst_a_n = 1'b0;
    #1;
    check_outs("debounce_reset_async", 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, "debounce_reset_hold");
    rst_a_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("after_abort%0d", i));

    // Recovery: a clean press still works after the aborted one.
    for (int k = 1; k <= 8; k++) step(1'b1, (k >= 7), (k == 7), 1'b0, $sformatf("recover_e%0d", k));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
